// File: rtl/sprite_blitter_if.sv
// Pixel-pipeline bundle shared by the VGA timing source, sprite ROM, palette and colour mixer.
interface sprite_blitter_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned SCALE_W = 3
);
  localparam int unsigned COORD_W = 10;
  localparam int unsigned CHAN_W  = 4;

  // Raster position from the VGA controller
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               blank;
  logic               frame_start;

  // Per-frame sprite configuration
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [SCALE_W-1:0] scale;
  logic               hflip;
  logic               enable;

  // Sprite ROM and palette
  logic [ADDR_W-1:0]  rom_address;
  logic [IDX_W-1:0]   rom_q;
  logic [IDX_W-1:0]   pal_index;
  logic [CHAN_W-1:0]  pal_red;
  logic [CHAN_W-1:0]  pal_green;
  logic [CHAN_W-1:0]  pal_blue;

  // Sprite colour toward the mixer
  logic [CHAN_W-1:0]  red;
  logic [CHAN_W-1:0]  green;
  logic [CHAN_W-1:0]  blue;
  logic               sprite_hit;

  // Blitter side
  modport slave (
    input  DrawX, DrawY, blank, frame_start,
    input  pos_x, pos_y, scale, hflip, enable,
    input  rom_q, pal_red, pal_green, pal_blue,
    output rom_address, pal_index,
    output red, green, blue, sprite_hit
  );

  // Raster / ROM / palette side
  modport master (
    output DrawX, DrawY, blank, frame_start,
    output pos_x, pos_y, scale, hflip, enable,
    output rom_q, pal_red, pal_green, pal_blue,
    input  rom_address, pal_index,
    input  red, green, blue, sprite_hit
  );
endinterface

// File: rtl/sprite_blitter.sv
// ROM-backed palette sprite renderer: shadowed per-frame config, integer upscale,
// horizontal flip and transparent index, addressed with incremental counters only.
module sprite_blitter #(
  parameter int unsigned SPR_W      = 44,
  parameter int unsigned SPR_H      = 22,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned SCALE_W    = 3,
  parameter int unsigned TRANSP_IDX = 0
) (
  input logic            vga_clk,
  input logic            reset,
  sprite_blitter_if.slave bus
);
  localparam int unsigned COORD_W = 10;
  localparam int unsigned BOX_W   = COORD_W + 1;
  localparam int unsigned CHAN_W  = 4;
  localparam int unsigned CX_W    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned RY_W    = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [COORD_W-1:0] H_ACTIVE  = COORD_W'(640);
  localparam logic [COORD_W-1:0] V_ACTIVE  = COORD_W'(480);
  localparam logic [CX_W-1:0]    CX_LAST   = CX_W'(SPR_W - 1);
  localparam logic [RY_W-1:0]    RY_LAST   = RY_W'(SPR_H - 1);
  localparam logic [ADDR_W-1:0]  ROW_STEP  = ADDR_W'(SPR_W);
  localparam logic [SCALE_W-1:0] SCALE_ONE = SCALE_W'(1);
  localparam logic [IDX_W-1:0]   CLEAR_IDX = IDX_W'(TRANSP_IDX);

  // Shadow configuration
  logic [COORD_W-1:0] sh_pos_x, sh_pos_y;
  logic [SCALE_W-1:0] sh_scale;
  logic               sh_hflip, sh_en;

  // Effective configuration for the current cycle
  logic [COORD_W-1:0] cfg_pos_x, cfg_pos_y;
  logic [SCALE_W-1:0] cfg_scale, scale_last;
  logic               cfg_hflip, cfg_en;

  // Box decode
  logic [BOX_W-1:0]   x_end, y_end;
  logic               in_x, in_y, on_screen, in_box;

  // Texel counters: registered, effective (after same-cycle clears) and next
  logic [SCALE_W-1:0] sx_q, sx_cur, sx_d;
  logic [CX_W-1:0]    cx_q, cx_cur, cx_d;
  logic [SCALE_W-1:0] sy_q, sy_cur, sy_d;
  logic [RY_W-1:0]    ry_q, ry_cur, ry_d;
  logic [ADDR_W-1:0]  base_q, base_cur, base_d;
  logic               line_hit_q, line_hit_cur, line_hit_d;
  logic               col_clear, blank_fall;

  // Address and pixel pipeline
  logic [CX_W-1:0]    col;
  logic [ADDR_W-1:0]  rom_addr;
  logic               blank_q;
  logic               hit0, hit_q;
  logic [CHAN_W-1:0]  red_q, green_q, blue_q;
  logic               sprite_hit_q;

  // Latch configuration on frame_start; scale 0 is stored as 1
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sh_pos_x <= '0;
      sh_pos_y <= '0;
      sh_scale <= SCALE_ONE;
      sh_hflip <= 1'b0;
      sh_en    <= 1'b0;
    end else if (bus.frame_start) begin
      sh_pos_x <= bus.pos_x;
      sh_pos_y <= bus.pos_y;
      sh_scale <= (bus.scale == '0) ? SCALE_ONE : bus.scale;
      sh_hflip <= bus.hflip;
      sh_en    <= bus.enable;
    end
  end

  // New values already govern the frame_start cycle itself
  always_comb begin
    cfg_pos_x = sh_pos_x;
    cfg_pos_y = sh_pos_y;
    cfg_scale = sh_scale;
    cfg_hflip = sh_hflip;
    cfg_en    = sh_en;
    if (bus.frame_start) begin
      cfg_pos_x = bus.pos_x;
      cfg_pos_y = bus.pos_y;
      cfg_scale = (bus.scale == '0) ? SCALE_ONE : bus.scale;
      cfg_hflip = bus.hflip;
      cfg_en    = bus.enable;
    end
    scale_last = cfg_scale - SCALE_ONE;
  end

  // Box test, one bit wider than the raster so far edges cannot wrap
  always_comb begin
    x_end     = BOX_W'({1'b0, cfg_pos_x}) + BOX_W'(SPR_W) * BOX_W'(cfg_scale);
    y_end     = BOX_W'({1'b0, cfg_pos_y}) + BOX_W'(SPR_H) * BOX_W'(cfg_scale);
    in_x      = (bus.DrawX >= cfg_pos_x) && ({1'b0, bus.DrawX} < x_end);
    in_y      = (bus.DrawY >= cfg_pos_y) && ({1'b0, bus.DrawY} < y_end);
    on_screen = (bus.DrawX < H_ACTIVE) && (bus.DrawY < V_ACTIVE);
    in_box    = bus.blank && in_x && in_y && on_screen;
  end

  // Column counters: cleared at the box left edge, stepped on every in-box pixel
  always_comb begin
    col_clear = bus.frame_start || (bus.blank && (bus.DrawX == cfg_pos_x));
    sx_cur    = col_clear ? '0 : sx_q;
    cx_cur    = col_clear ? '0 : cx_q;
    sx_d      = sx_cur;
    cx_d      = cx_cur;
    if (in_box) begin
      if (sx_cur >= scale_last) begin
        sx_d = '0;
        cx_d = (cx_cur == CX_LAST) ? '0 : cx_cur + CX_W'(1);
      end else begin
        sx_d = sx_cur + SCALE_W'(1);
      end
    end
  end

  // Row counters: advance once per drawn line at the end of active video
  always_comb begin
    blank_fall   = blank_q && !bus.blank;
    sy_cur       = bus.frame_start ? '0 : sy_q;
    ry_cur       = bus.frame_start ? '0 : ry_q;
    base_cur     = bus.frame_start ? '0 : base_q;
    line_hit_cur = bus.frame_start ? 1'b0 : line_hit_q;
    sy_d         = sy_cur;
    ry_d         = ry_cur;
    base_d       = base_cur;
    line_hit_d   = line_hit_cur || in_box;
    if (blank_fall && line_hit_cur) begin
      line_hit_d = 1'b0;
      if (sy_cur >= scale_last) begin
        sy_d = '0;
        if (ry_cur != RY_LAST) begin
          ry_d   = ry_cur + RY_W'(1);
          base_d = base_cur + ROW_STEP;
        end
      end else begin
        sy_d = sy_cur + SCALE_W'(1);
      end
    end
  end

  // Counter and blank-history registers
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sx_q       <= '0;
      cx_q       <= '0;
      sy_q       <= '0;
      ry_q       <= '0;
      base_q     <= '0;
      line_hit_q <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      sx_q       <= sx_d;
      cx_q       <= cx_d;
      sy_q       <= sy_d;
      ry_q       <= ry_d;
      base_q     <= base_d;
      line_hit_q <= line_hit_d;
      blank_q    <= bus.blank;
    end
  end

  // Texel address: running row base plus (optionally mirrored) column
  always_comb begin
    col      = cfg_hflip ? (CX_LAST - cx_cur) : cx_cur;
    rom_addr = base_cur + ADDR_W'(col);
    hit0     = cfg_en && in_box;
  end

  assign bus.rom_address = rom_addr;
  assign bus.pal_index   = bus.rom_q;

  // Delay the hit flag to line up with ROM data
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit0;
    end
  end

  // Output stage: opaque texels pass the palette colour, everything else is black
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      sprite_hit_q <= 1'b0;
    end else if (hit_q && (bus.rom_q != CLEAR_IDX)) begin
      red_q        <= bus.pal_red;
      green_q      <= bus.pal_green;
      blue_q       <= bus.pal_blue;
      sprite_hit_q <= 1'b1;
    end else begin
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      sprite_hit_q <= 1'b0;
    end
  end

  assign bus.red        = red_q;
  assign bus.green      = green_q;
  assign bus.blue       = blue_q;
  assign bus.sprite_hit = sprite_hit_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: directed frames plus random frames, checked every cycle
// against a coordinate-arithmetic model of the sprite box and texel lookup.
module tb_sprite_blitter;
  localparam int unsigned SPR_W   = 44;
  localparam int unsigned SPR_H   = 22;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned SCALE_W = 3;
  localparam int ROM_DEPTH = 1 << ADDR_W;

  typedef struct packed {
    bit             pend;
    bit             hit;
    bit [IDX_W-1:0] idx;
    bit [3:0]       r;
    bit [3:0]       g;
    bit [3:0]       b;
  } ent_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b0;
  int checks   = 0;
  int failures = 0;
  int hit_cnt  = 0;

  // Model configuration (what the shadow registers should hold)
  int m_px = 0;
  int m_py = 0;
  int m_s  = 1;
  bit m_hf = 1'b0;
  bit m_en = 1'b0;

  logic [IDX_W-1:0] rom_mem [ROM_DEPTH];

  sprite_blitter_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .SCALE_W(SCALE_W)) bus ();

  sprite_blitter #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W),
    .IDX_W(IDX_W), .SCALE_W(SCALE_W), .TRANSP_IDX(0)
  ) dut (
    .vga_clk(vga_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] pal_r(input logic [IDX_W-1:0] i);
    return {1'b0, i};
  endfunction
  function automatic logic [3:0] pal_g(input logic [IDX_W-1:0] i);
    return {i, 1'b1};
  endfunction
  function automatic logic [3:0] pal_b(input logic [IDX_W-1:0] i);
    return ~{1'b0, i};
  endfunction

  // One-cycle-latency ROM and combinational palette
  always @(posedge vga_clk) bus.rom_q <= rom_mem[bus.rom_address];
  always_comb begin
    bus.pal_red   = pal_r(bus.pal_index);
    bus.pal_green = pal_g(bus.pal_index);
    bus.pal_blue  = pal_b(bus.pal_index);
  end

  function automatic bit m_hit(input int x, input int y, input bit b);
    return m_en && b && (x >= m_px) && (x < m_px + int'(SPR_W) * m_s) &&
           (y >= m_py) && (y < m_py + int'(SPR_H) * m_s) && (x < 640) && (y < 480);
  endfunction

  function automatic int m_addr(input int x, input int y);
    int c;
    c = (x - m_px) / m_s;
    if (m_hf) c = int'(SPR_W) - 1 - c;
    return ((y - m_py) / m_s) * int'(SPR_W) + c;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic scramble_cfg();
    bus.pos_x  = 10'($urandom_range(0, 1023));
    bus.pos_y  = 10'($urandom_range(0, 1023));
    bus.scale  = 3'($urandom_range(0, 7));
    bus.hflip  = 1'($urandom_range(0, 1));
    bus.enable = 1'($urandom_range(0, 1));
  endtask

  // One pixel clock; configuration inputs wander freely outside frame_start
  task automatic tick(input int x, input int y, input bit b);
    @(posedge vga_clk);
    #1;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.blank       = b;
    bus.frame_start = 1'b0;
    scramble_cfg();
  endtask

  task automatic start_frame(input int px, input int py, input int sc, input bit hf, input bit en);
    @(posedge vga_clk);
    #1;
    bus.DrawX       = '0;
    bus.blank       = 1'b0;
    bus.frame_start = 1'b1;
    bus.pos_x       = 10'(px);
    bus.pos_y       = 10'(py);
    bus.scale       = 3'(sc);
    bus.hflip       = hf;
    bus.enable      = en;
    m_px = px;
    m_py = py;
    m_s  = (sc == 0) ? 1 : sc;
    m_hf = hf;
    m_en = en;
    hit_cnt = 0;
  endtask

  task automatic run_lines(input int y_lo, input int y_hi, input int x_lo, input int x_hi);
    for (int y = y_lo; y <= y_hi; y++) begin
      for (int x = x_lo; x <= x_hi; x++) tick(x, y, 1'b1);
      for (int k = 1; k <= 4; k++) tick(x_hi + k, y, 1'b0);
    end
  endtask

  // Per-cycle compare: address now, palette index one cycle later, colour two cycles later
  initial begin : compare
    ent_t p1, p2, cur;
    int a;
    p1 = '0;
    p2 = '0;
    forever begin
      @(negedge vga_clk);
      if (reset) begin
        chk("reset_outputs", int'({bus.sprite_hit, bus.red, bus.green, bus.blue}), 0);
        p1 = '0;
        p2 = '0;
      end else begin
        cur = '0;
        if (m_hit(int'(bus.DrawX), int'(bus.DrawY), bus.blank)) begin
          a = m_addr(int'(bus.DrawX), int'(bus.DrawY));
          chk("rom_address", int'(bus.rom_address), a);
          cur.pend = 1'b1;
          cur.idx  = rom_mem[a];
          cur.hit  = (rom_mem[a] != '0);
          if (cur.hit) begin
            cur.r = pal_r(rom_mem[a]);
            cur.g = pal_g(rom_mem[a]);
            cur.b = pal_b(rom_mem[a]);
          end
        end
        if (p1.pend) chk("pal_index", int'(bus.pal_index), int'(p1.idx));
        chk("sprite_hit", int'(bus.sprite_hit), int'(p2.hit));
        chk("rgb", int'({bus.red, bus.green, bus.blue}), int'({p2.r, p2.g, p2.b}));
        if (bus.sprite_hit === 1'b1) hit_cnt++;
        p2 = p1;
        p1 = cur;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int px, py, sc, s;
    bit hf, en;
    for (int k = 0; k < ROM_DEPTH; k++) rom_mem[k] = IDX_W'(k % 8);
    bus.DrawX = '0;
    bus.DrawY = '0;
    bus.blank = 1'b0;
    bus.frame_start = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    bus.scale = '0;
    bus.hflip = 1'b0;
    bus.enable = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("reset_sprite_hit", int'(bus.sprite_hit), 0);
    chk("reset_rgb", int'({bus.red, bus.green, bus.blue}), 0);
    chk("reset_rom_address", int'(bus.rom_address), 0);
    reset = 1'b0;

    // No frame_start since reset: nothing may be drawn
    hit_cnt = 0;
    run_lines(0, 9, 0, 639);
    chk("noframe_hits", hit_cnt, 0);

    // scale 1 at (100,50)
    start_frame(100, 50, 1, 1'b0, 1'b1);
    chk("pin_a_right_edge", int'(m_hit(144, 60, 1'b1)), 0);
    chk("pin_a_bottom_edge", int'(m_hit(120, 72, 1'b1)), 0);
    chk("pin_a_last_pixel", int'(m_hit(143, 71, 1'b1)), 1);
    chk("pin_a_addr", m_addr(101, 51), 45);
    run_lines(48, 74, 96, 150);
    chk("a_hits", hit_cnt, 847);

    // scale 3 at origin
    start_frame(0, 0, 3, 1'b0, 1'b1);
    chk("pin_b_line3_addr", m_addr(0, 3), 44);
    chk("pin_b_texel_repeat", m_addr(5, 2), 1);
    chk("pin_b_box_end", int'(m_hit(131, 65, 1'b1)), 1);
    chk("pin_b_past_x", int'(m_hit(132, 65, 1'b1)), 0);
    chk("pin_b_past_y", int'(m_hit(131, 66, 1'b1)), 0);
    run_lines(0, 67, 0, 135);
    chk("b_hits", hit_cnt, 7623);

    // horizontal flip
    start_frame(200, 10, 1, 1'b1, 1'b1);
    chk("pin_c_first_addr", m_addr(200, 10), 43);
    chk("pin_c_last_addr", m_addr(243, 10), 0);
    run_lines(8, 33, 196, 250);
    chk("c_hits", hit_cnt, 847);

    // right-edge clip at 640 with scale 2; active driven past 640 on purpose
    start_frame(620, 100, 2, 1'b0, 1'b1);
    chk("pin_d_clip", int'(m_hit(640, 110, 1'b1)), 0);
    run_lines(98, 145, 616, 700);
    chk("d_hits", hit_cnt, 748);

    // scale 0 treated as 1; bottom clip at 480 with active driven past it
    start_frame(300, 470, 0, 1'b0, 1'b1);
    run_lines(468, 495, 296, 350);
    chk("e_hits", hit_cnt, 385);

    // Async reset in the middle of a drawn line
    start_frame(50, 20, 1, 1'b0, 1'b1);
    run_lines(18, 24, 46, 100);
    for (int x = 46; x <= 70; x++) tick(x, 25, 1'b1);
    #2 reset = 1'b1;
    m_en = 1'b0;
    m_px = 0;
    m_py = 0;
    m_s  = 1;
    m_hf = 1'b0;
    #1;
    chk("async_reset_hit", int'(bus.sprite_hit), 0);
    chk("async_reset_rgb", int'({bus.red, bus.green, bus.blue}), 0);
    chk("async_reset_addr", int'(bus.rom_address), 0);
    tick(71, 25, 1'b1);
    tick(72, 25, 1'b1);
    reset = 1'b0;
    for (int x = 73; x <= 100; x++) tick(x, 25, 1'b1);
    for (int k = 1; k <= 4; k++) tick(100 + k, 25, 1'b0);
    hit_cnt = 0;
    run_lines(26, 40, 46, 100);
    chk("post_reset_hits", hit_cnt, 0);

    // Random frames with random ROM contents
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < ROM_DEPTH; k++) rom_mem[k] = IDX_W'($urandom_range(0, 7));
      px = int'($urandom_range(0, 639));
      py = int'($urandom_range(0, 470));
      sc = int'($urandom_range(0, 2));
      hf = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      s  = (sc == 0) ? 1 : sc;
      start_frame(px, py, sc, hf, en);
      run_lines((py > 2) ? py - 2 : 0, py + int'(SPR_H) * s + 1,
                (px > 3) ? px - 3 : 0,
                (px + int'(SPR_W) * s + 2 < 660) ? px + int'(SPR_W) * s + 2 : 660);
    end

    repeat (4) @(posedge vga_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite renderer for the VGA pixel pipeline. Draws one ROM-backed palette sprite at a runtime position with integer upscaling, horizontal flip and a transparent colour index. It replaces per-pixel multiply/divide address maths with incremental counters. It sits between the VGA controller's DrawX/DrawY/blank outputs and the colour mixer, driving a 1-cycle-latency sprite ROM and a combinational palette.

## Interface
- SPR_W, 44: sprite width in texels
- SPR_H, 22: sprite height in texels
- ADDR_W, 10: ROM address width; must satisfy 2^ADDR_W ≥ SPR_W*SPR_H
- IDX_W, 3: palette index width
- SCALE_W, 3: scale field width
- TRANSP_IDX, 0: palette index treated as transparent

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- frame_start  in  1  one-cycle pulse; latches configuration
- pos_x  in  10  sprite top-left column
- pos_y  in  10  sprite top-left row
- scale  in  SCALE_W  integer magnification; 0 is treated as 1
- hflip  in  1  mirror horizontally
- enable  in  1  sprite visible
- rom_address  out  ADDR_W  texel address to ROM
- rom_q  in  IDX_W  ROM data, valid 1 cycle after address
- pal_index  out  IDX_W  equals rom_q, to the palette
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index
- red, green, blue  out  4 each  registered sprite colour
- sprite_hit  out  1  registered; 1 = opaque sprite pixel at this output

## Operation
- **Shadow configuration:** on frame_start, latch pos_x, pos_y, scale (0→1), hflip and enable into shadow registers. Reset all texel counters on the same pulse. All drawing uses the shadow copy, so mid-frame input changes have no effect until the next pulse.
- **Box:** S = shadow scale. The sprite box is pos_x ≤ DrawX < pos_x + SPR_W*S and pos_y ≤ DrawY < pos_y + SPR_H*S, computed 11 bits wide so the box edges do not wrap. Box regions at DrawX ≥ 640 or DrawY ≥ 480 are never drawn.
- **Column counters:** sub-column sx (0..S-1) and texel column cx (0..SPR_W-1). Both are cleared on each cycle with blank=1 and DrawX == pos_x. On each in-box cycle, sx increments; when sx == S-1, sx wraps to 0 and cx increments.
- **Row counters:** sub-row sy and texel row ry. Set line_hit when any in-box pixel occurs on the line. On the blank 1→0 edge with line_hit set, advance sy/ry with the same wrap rule, then clear line_hit. ry saturates at SPR_H-1.
- **Address:** col = hflip ? SPR_W-1-cx : cx; rom_address = ry*SPR_W + col. Implement the multiply as a running row base that adds SPR_W whenever ry increments. No dividers are used.
- **Hit:** stage-0 hit = enable & blank & in-box. The hit and blank flags are delayed to match the ROM latency.
- **Output stage:** if delayed hit and rom_q != TRANSP_IDX, then red/green/blue = pal_*, sprite_hit = 1. Otherwise outputs = 0 and sprite_hit = 0.
- **Reset:** async. red/green/blue/sprite_hit = 0, rom_address = 0, all counters and line_hit = 0, shadow enable = 0, shadow scale = 1, shadow pos/hflip = 0.

## Timing
- Latency is 2 cycles: DrawX/DrawY at cycle n, rom_address at cycle n (combinational from counters), rom_q at n+1, red/green/blue/sprite_hit registered at n+2.
- The VGA controller is responsible for the 2-cycle compensation of sync signals.
- DrawX is required to advance by exactly 1 per active cycle. No other ordering is supported.
- frame_start during active video still applies immediately, with counters reset. The rest of that frame may be mis-addressed. This is legal; the block must not hang.
- frame_start coincident with an in-box pixel: the new shadow values govern that same cycle.
- Reset asserted mid-line: outputs drop to 0 asynchronously. After release, nothing is drawn until a frame_start with enable = 1.

## Test plan
- Reset release with no frame_start, full frame of stimulus → sprite_hit = 0 and rgb = 0 on all pixels.
- pos = (100,50), scale = 1, ROM texel k = k mod 8, palette identity, TRANSP_IDX = 0 → at DrawX = 100+c, DrawY = 50+r, output 2 cycles later has sprite_hit = (idx != 0) and rgb = idx. No hit at DrawX = 144 or DrawY = 72.
- scale = 3, pos = (0,0) → each texel is repeated on 3 consecutive pixels and 3 consecutive lines. Box ends at DrawX = 131 and DrawY = 65. rom_address on line 3 starts at 44.
- hflip = 1, scale = 1 → first box pixel addresses 43, last addresses 0.
- pos_x = 620, scale = 2 → only 10 texels are drawn per line, and rows still advance correctly on the next line.
- Change pos_x mid-frame without frame_start → rendering is unchanged until the next frame_start. scale = 0 → behaves as scale = 1.
